// File: rtl/pd_dw_nr_rd.sv
// PD RAM readout: sums the antenna energies of each symbol, streams one combined
// power per symbol over valid/ready and reports the frame's minimum-power symbol.
module pd_dw_nr_rd #(
    parameter int unsigned NSYMB  = 280,
    parameter int unsigned NANT   = 4,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned DW     = 48,
    localparam int unsigned SW    = $clog2(NSYMB),
    localparam int unsigned AW    = $clog2(NANT),
    localparam int unsigned PW    = DW + AW
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             i_start,
    output logic             o_rd_en,
    output logic [SW+AW-1:0] o_rd_addr,
    input  logic [DW-1:0]    i_rd_data,
    output logic             o_vld,
    input  logic             i_rdy,
    output logic [SW-1:0]    o_symb,
    output logic [PW-1:0]    o_pwr,
    output logic             o_last,
    output logic             o_busy,
    output logic             o_done,
    output logic [PW-1:0]    o_min_pwr,
    output logic [SW-1:0]    o_min_symb
);

    typedef enum logic [2:0] {IDLE, RD, WAIT, OUT, DONE} state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       symb_q, symb_d;
    logic [AW-1:0]       ant_q, ant_d;
    logic [AW-1:0]       ret_q, ret_d;
    logic [RD_LAT-1:0]   pipe_q, pipe_d;
    logic [PW-1:0]       acc_q, acc_d;
    logic                rd_en_q, rd_en_d;
    logic [SW+AW-1:0]    rd_addr_q, rd_addr_d;
    logic                vld_q, vld_d;
    logic [PW-1:0]       pwr_q, pwr_d;
    logic [SW-1:0]       osymb_q, osymb_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [PW-1:0]       min_pwr_q, min_pwr_d;
    logic [SW-1:0]       min_symb_q, min_symb_d;
    logic [PW-1:0]       run_min_q, run_min_d;
    logic [SW-1:0]       run_symb_q, run_symb_d;

    logic [PW-1:0]       acc_sum;
    logic                cap;
    logic                beat_lt;
    logic [SW-1:0]       symb_nxt;

    assign cap      = pipe_q[RD_LAT-1];
    assign acc_sum  = acc_q + PW'(i_rd_data);
    assign beat_lt  = (pwr_q < run_min_q);
    assign symb_nxt = symb_q + SW'(1);

    // State and datapath registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            symb_q     <= '0;
            ant_q      <= '0;
            ret_q      <= '0;
            pipe_q     <= '0;
            acc_q      <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            vld_q      <= 1'b0;
            pwr_q      <= '0;
            osymb_q    <= '0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            min_pwr_q  <= '1;
            min_symb_q <= '0;
            run_min_q  <= '1;
            run_symb_q <= '0;
        end else begin
            state_q    <= state_d;
            symb_q     <= symb_d;
            ant_q      <= ant_d;
            ret_q      <= ret_d;
            pipe_q     <= pipe_d;
            acc_q      <= acc_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            vld_q      <= vld_d;
            pwr_q      <= pwr_d;
            osymb_q    <= osymb_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            min_pwr_q  <= min_pwr_d;
            min_symb_q <= min_symb_d;
            run_min_q  <= run_min_d;
            run_symb_q <= run_symb_d;
        end
    end

    // Next-state, read sequencing, accumulation and minimum tracking
    always_comb begin
        state_d    = state_q;
        symb_d     = symb_q;
        ant_d      = ant_q;
        ret_d      = ret_q;
        pipe_d     = (pipe_q << 1) | RD_LAT'(rd_en_q);
        acc_d      = acc_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        vld_d      = vld_q;
        pwr_d      = pwr_q;
        osymb_d    = osymb_q;
        last_d     = last_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        min_pwr_d  = min_pwr_q;
        min_symb_d = min_symb_q;
        run_min_d  = run_min_q;
        run_symb_d = run_symb_q;

        // Returning read data lands RD_LAT cycles after its read enable
        if (cap) begin
            acc_d = acc_sum;
            ret_d = ret_q + AW'(1);
        end

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d    = RD;
                    symb_d     = '0;
                    ant_d      = '0;
                    ret_d      = '0;
                    acc_d      = '0;
                    rd_en_d    = 1'b1;
                    rd_addr_d  = '0;
                    busy_d     = 1'b1;
                    run_min_d  = '1;
                    run_symb_d = '0;
                end
            end
            RD: begin
                if (ant_q == AW'(NANT - 1)) begin
                    state_d = WAIT;
                end else begin
                    ant_d     = ant_q + AW'(1);
                    rd_en_d   = 1'b1;
                    rd_addr_d = {symb_q, ant_q + AW'(1)};
                end
            end
            WAIT: begin
                if (cap && (ret_q == AW'(NANT - 1))) begin
                    state_d = OUT;
                    vld_d   = 1'b1;
                    pwr_d   = acc_sum;
                    osymb_d = symb_q;
                    last_d  = (symb_q == SW'(NSYMB - 1));
                end
            end
            OUT: begin
                if (i_rdy) begin
                    vld_d  = 1'b0;
                    last_d = 1'b0;
                    if (beat_lt) begin
                        run_min_d  = pwr_q;
                        run_symb_d = osymb_q;
                    end
                    if (osymb_q == SW'(NSYMB - 1)) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        min_pwr_d  = beat_lt ? pwr_q : run_min_q;
                        min_symb_d = beat_lt ? osymb_q : run_symb_q;
                    end else begin
                        state_d   = RD;
                        symb_d    = symb_nxt;
                        ant_d     = '0;
                        ret_d     = '0;
                        acc_d     = '0;
                        rd_en_d   = 1'b1;
                        rd_addr_d = {symb_nxt, AW'(0)};
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_rd_en    = rd_en_q;
    assign o_rd_addr  = rd_addr_q;
    assign o_vld      = vld_q;
    assign o_symb     = osymb_q;
    assign o_pwr      = pwr_q;
    assign o_last     = last_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_min_pwr  = min_pwr_q;
    assign o_min_symb = min_symb_q;

endmodule

// File: tb/tb_pd_dw_nr_rd.sv
// Bench for pd_dw_nr_rd: RAM model, per-symbol scoreboard, frame table and
// hand-written stall / restart / reset / latency sequences.
module tb_pd_dw_nr_rd;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        i_start;
    logic        i_rdy;
    logic        o_rd_en;
    logic [10:0] o_rd_addr;
    logic [47:0] i_rd_data;
    logic        o_vld;
    logic [8:0]  o_symb;
    logic [49:0] o_pwr;
    logic        o_last;
    logic        o_busy;
    logic        o_done;
    logic [49:0] o_min_pwr;
    logic [8:0]  o_min_symb;

    logic        start3;
    logic        rd_en3;
    logic [10:0] rd_addr3;
    logic [47:0] rd_data3;
    logic        vld3;
    logic [8:0]  symb3;
    logic [49:0] pwr3;
    logic        last3;
    logic        busy3;
    logic        done3;
    logic [49:0] min_pwr3;
    logic [8:0]  min_symb3;

    always #2 sys_clk = ~sys_clk;

    pd_dw_nr_rd #(.NSYMB(280), .NANT(4), .RD_LAT(2), .DW(48)) u_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .i_start(i_start),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
        .o_vld(o_vld), .i_rdy(i_rdy), .o_symb(o_symb), .o_pwr(o_pwr),
        .o_last(o_last), .o_busy(o_busy), .o_done(o_done),
        .o_min_pwr(o_min_pwr), .o_min_symb(o_min_symb)
    );

    pd_dw_nr_rd #(.NSYMB(280), .NANT(4), .RD_LAT(3), .DW(48)) u_dut3 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .i_start(start3),
        .o_rd_en(rd_en3), .o_rd_addr(rd_addr3), .i_rd_data(rd_data3),
        .o_vld(vld3), .i_rdy(1'b1), .o_symb(symb3), .o_pwr(pwr3),
        .o_last(last3), .o_busy(busy3), .o_done(done3),
        .o_min_pwr(min_pwr3), .o_min_symb(min_symb3)
    );

    // PD RAM model with 2- and 3-cycle read pipelines
    logic [47:0] mem [0:2047];
    logic [47:0] r2a, r2b, r3a, r3b, r3c;
    always @(posedge sys_clk) begin
        r2a <= mem[o_rd_addr];
        r2b <= r2a;
        r3a <= mem[rd_addr3];
        r3b <= r3a;
        r3c <= r3b;
    end
    assign i_rd_data = r2b;
    assign rd_data3  = r3c;

    typedef struct {
        int          mode;
        int          stall;
        int          xstart;
        int          rst_at;
        logic [49:0] mn;
        logic [8:0]  mns;
    } frame_t;

    frame_t      vecs [4];
    logic [59:0] exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic fill(input int mode);
        for (int s = 0; s < 512; s++) begin
            for (int a = 0; a < 4; a++) begin
                case (mode)
                    0:       mem[s*4+a] = 48'(s*16 + a + 1);
                    1:       mem[s*4+a] = 48'hFFFF_FFFF_FFFF;
                    default: mem[s*4+a] = (s == 100 || s == 200) ? 48'd1 : 48'(1000 + s*4 + a);
                endcase
            end
        end
    endtask

    task automatic push_frame();
        logic [49:0] sum;
        for (int s = 0; s < 280; s++) begin
            sum = '0;
            for (int a = 0; a < 4; a++) sum = sum + 50'(mem[s*4+a]);
            exp_q.push_back({9'(s), sum, (s == 279)});
        end
    endtask

    task automatic run_frame(input frame_t f);
        logic [59:0] e;
        logic [59:0] hold;
        logic        prev_last = 1'b0;
        logic        stalled   = 1'b0;
        logic        xdone     = 1'b0;
        logic        resume    = 1'b0;
        logic        fin       = 1'b0;
        int          t_rd      = -1;
        int          t_vld     = -1;
        int          c0;

        fill(f.mode);
        push_frame();
        c0 = cyc;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("busy_start", 64'(o_busy), 64'd1);

        for (int k = 0; k < 4000 && !fin; k++) begin
            if (resume) begin
                resume = 1'b0;
                chk("resume_rd", {o_rd_en, o_rd_addr}, {1'b1, 11'((f.stall + 1) * 4)});
            end
            if (t_rd < 0 && o_rd_en) t_rd = cyc;
            if (t_vld < 0 && o_vld) begin
                t_vld = cyc;
                chk("latency", 64'(t_vld - t_rd), 64'd6);
            end

            if (f.rst_at >= 0 && o_vld && o_symb == 9'(f.rst_at)) begin
                sys_rst = 1'b1;
                #1;
                chk("rst_abort_ctl", {o_vld, o_rd_en, o_busy, o_done, o_last}, 64'd0);
                chk("rst_abort_data", {o_pwr, o_symb, o_min_symb}, 64'd0);
                chk("rst_abort_min", 64'(o_min_pwr), 64'h3_FFFF_FFFF_FFFF);
                exp_q.delete();
                for (int j = 0; j < 3; j++) step();
                sys_rst = 1'b0;
                for (int j = 0; j < 6; j++) begin
                    step();
                    chk("no_restart", {o_done, o_busy, o_rd_en}, 64'd0);
                end
                return;
            end

            if (o_done) begin
                chk("done_after_last", 64'(prev_last), 64'd1);
                chk("min_pwr", 64'(o_min_pwr), 64'(f.mn));
                chk("min_symb", 64'(o_min_symb), 64'(f.mns));
                chk("busy_at_done", 64'(o_busy), 64'd0);
                if (f.stall < 0) chk("frame_cycles", 64'(cyc - c0 + 1), 64'(280*7 + 2));
                i_start = 1'b1;
                step();
                i_start = 1'b0;
                chk("done_cycle_start_ignored", {o_done, o_busy, o_rd_en}, 64'd0);
                chk("queue_empty", 64'(exp_q.size()), 64'd0);
                fin = 1'b1;
            end else begin
                if (f.stall >= 0 && !stalled && o_vld && o_symb == 9'(f.stall)) begin
                    stalled = 1'b1;
                    i_rdy   = 1'b0;
                    hold    = {o_symb, o_pwr, o_last};
                    for (int j = 0; j < 5; j++) begin
                        step();
                        chk("stall_hold", {o_vld, o_symb, o_pwr, o_last}, {1'b1, hold});
                        chk("stall_no_rd", 64'(o_rd_en), 64'd0);
                    end
                    i_rdy  = 1'b1;
                    resume = 1'b1;
                end
                if (f.xstart >= 0 && !xdone && o_vld && o_symb == 9'(f.xstart)) begin
                    xdone   = 1'b1;
                    i_start = 1'b1;
                end
                if (o_vld && i_rdy) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", {o_symb, o_pwr, o_last}, e);
                    end
                    prev_last = o_last;
                end else begin
                    prev_last = 1'b0;
                end
                step();
                i_start = 1'b0;
            end
        end
        if (!fin) chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int t_rd3;
        int t_vld3;

        vecs[0] = '{mode: 0, stall: -1, xstart: 50, rst_at: -1, mn: 50'd10,                mns: 9'd0};
        vecs[1] = '{mode: 1, stall: 3,  xstart: -1, rst_at: -1, mn: 50'h3_FFFF_FFFF_FFFC,  mns: 9'd0};
        vecs[2] = '{mode: 2, stall: -1, xstart: -1, rst_at: 120, mn: 50'd0,                mns: 9'd0};
        vecs[3] = '{mode: 2, stall: -1, xstart: -1, rst_at: -1, mn: 50'd4,                 mns: 9'd100};

        sys_rst = 1'b1;
        i_start = 1'b0;
        start3  = 1'b0;
        i_rdy   = 1'b1;
        fill(0);
        for (int j = 0; j < 3; j++) step();
        chk("reset_ctl", {o_vld, o_rd_en, o_busy, o_done, o_last}, 64'd0);
        chk("reset_data", {o_pwr, o_symb, o_min_symb}, 64'd0);
        chk("reset_addr", 64'(o_rd_addr), 64'd0);
        chk("reset_min", 64'(o_min_pwr), 64'h3_FFFF_FFFF_FFFF);
        sys_rst = 1'b0;
        step();

        // Latency with a 3-cycle RAM
        t_rd3  = -1;
        t_vld3 = -1;
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        for (int j = 0; j < 30 && t_vld3 < 0; j++) begin
            if (t_rd3 < 0 && rd_en3) t_rd3 = cyc;
            if (vld3) begin
                t_vld3 = cyc;
                chk("latency_rdlat3", 64'(t_vld3 - t_rd3), 64'd7);
                chk("pwr_rdlat3", 64'(pwr3), 64'd10);
            end
            if (t_vld3 < 0) step();
        end
        if (t_vld3 < 0) chk("rdlat3_timeout", 64'd0, 64'd1);

        for (int i = 0; i < 4; i++) run_frame(vecs[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
